aes_enc_arbiter: RTL
====================

Name: aes_enc_arbiter

Overview:
- Shares one combinational AES_Encryption core between two requesters.
- Each requester uses a valid/ready request channel: 128-bit plaintext plus 128-bit key.
- Grants one request at a time and registers the operands into the core.
- Waits a fixed settle window (multicycle path through the core), captures the cipher and returns it with a requester ID on a valid/ready response channel.

Parameters:
- SETTLE_CYCLES, 4, cycles between operand registration and cipher capture; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_pt  in  128  requester 0 plaintext
- req0_key  in  128  requester 0 key
- req1_valid  in  1  requester 1 has a request
- req1_ready  out  1  requester 1 request accepted this cycle
- req1_pt  in  128  requester 1 plaintext
- req1_key  in  128  requester 1 key
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester ID of response
- rsp_cipher  out  128  ciphertext
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Core hookup: internal AES_Encryption instance, driven only from registers pt_q and key_q; its cipher output is sampled only at the capture edge.
- State IDLE:
  - reqN_ready = (state==IDLE) && grant==N, combinational.
  - Never both readies high.
  - On handshake: pt_q/key_q ← the granted requester's operands; id_q ← N; cnt ← SETTLE_CYCLES-1; go to WAIT.
- Arbitration (round-robin):
  - Only one valid → it is granted.
  - Both valid → grant the requester not served last.
  - last_srv updates on each accepted request.
  - Reset value last_srv=1, so requester 0 wins the first tie.
- State WAIT:
  - cnt decrements each cycle.
  - When cnt==0: rsp_cipher ← core cipher, rsp_id ← id_q, rsp_valid ← 1, go to RESP.
  - Result: rsp_valid rises exactly SETTLE_CYCLES clock edges after the accept edge.
- State RESP:
  - Hold rsp_valid, rsp_id and rsp_cipher stable until rsp_ready.
  - On handshake: rsp_valid ← 0, go to IDLE.
  - No request is accepted in RESP.
  - Minimum spacing between accepts is SETTLE_CYCLES+2 cycles.
- Operand isolation: pt_q/key_q are unchanged outside the accept edge. Input changes after accept do not affect the result.
- Requester contract:
  - A requester may drop valid before ready without penalty.
  - No internal queuing; an unserved requester is simply not granted.
- Reset values: state=IDLE, pt_q=key_q=0, cnt=0, rsp_valid=0, rsp_id=0, rsp_cipher=0, busy=0, last_srv=1, readies=0.
- Reset mid-operation: any in-flight or unconsumed transaction is discarded; no response is produced after reset release.
- Width rule: cnt is 4 bits. SETTLE_CYCLES outside 1..15 is a synthesis-time error (generate-block $error).

Optional Feature:
- Macro: AES_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins ties; last_srv is not implemented and does not affect arbitration.
- Undefined: round-robin as above.

Test Plan:
- Single request: req0 pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, rsp_ready=1 → req0_ready high in the accept cycle; rsp_valid exactly 4 edges later; rsp_id=0; rsp_cipher=69c4e0d86a7b0430d8cdb78070b4c55a.
- Tie and round-robin: both valid from reset, req1 pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c →
  - first response: id 0, cipher 69c4e0d8…c55a;
  - second response: id 1, cipher 3925841d02dc09fbdc118597196a0b32;
  - third grant (both still valid): requester 0.
- Response backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_valid, rsp_id and rsp_cipher stable; both readies low; busy=1. Release → IDLE on the next cycle.
- Operand isolation: change req0_pt one cycle after accept → cipher still matches the originally accepted operands.
- Reset mid-WAIT: assert rst_n=0 two cycles after accept → rsp_valid, busy and readies 0 immediately. After release with no valids, no response appears within 20 cycles.
- AES_ARB_FIXED_PRIO_EN defined, both valid continuously → every response carries rsp_id=0.

Source files
------------

// File: rtl/aes_enc_arbiter.sv
// Two-requester arbiter sharing one combinational AES-128 core, with a multicycle settle window.
// Define AES_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.

module AES_Encryption (
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] cipher
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box computed as x^254 (GF(2^8) inverse, 0 maps to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    inv  = gmul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127-8*(rr+4*c) -: 8] = sbox(s[127-8*(rr+4*((c+rr)%4)) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] k0);
    logic [127:0] s;
    logic [127:0] k;
    logic [7:0]   rc;
    s  = pt ^ k0;
    k  = k0;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s);
      if (r != 10) s = mix_columns(s);
      k  = key_next(k, rc);
      s  = s ^ k;
      rc = xtime(rc);
    end
    return s;
  endfunction

  assign cipher = encrypt(plaintext, key);

endmodule

module aes_enc_arbiter #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_pt,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_pt,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_cipher,
  output logic         busy
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("aes_enc_arbiter: SETTLE_CYCLES must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t       state_q, state_d;
  logic [127:0] pt_q, pt_d, key_q, key_d;
  logic [127:0] rsp_cipher_q, rsp_cipher_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         id_q, id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic         grant;
  logic         accept;
  logic [127:0] core_cipher;

  AES_Encryption u_core (
    .plaintext (pt_q),
    .key       (key_q),
    .cipher    (core_cipher)
  );

`ifdef AES_ARB_FIXED_PRIO_EN
  assign grant = !req0_valid;
`else
  logic last_srv_q, last_srv_d;

  // Ties go to whoever was not served last; a lone requester is always granted
  always_comb begin
    grant = !req0_valid;
    if (req0_valid && req1_valid) grant = !last_srv_q;
    last_srv_d = accept ? grant : last_srv_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_srv_q <= 1'b1;
    else        last_srv_q <= last_srv_d;
  end
`endif

  // Readies are held low while reset is asserted, even though the state already reads IDLE
  assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    pt_d         = pt_q;
    key_d        = key_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_cipher_d = rsp_cipher_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pt_d    = grant ? req1_pt : req0_pt;
          key_d   = grant ? req1_key : req0_key;
          id_d    = grant;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_cipher_d = core_cipher;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pt_q         <= '0;
      key_q        <= '0;
      id_q         <= 1'b0;
      cnt_q        <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_cipher_q <= '0;
    end else begin
      state_q      <= state_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_cipher_q <= rsp_cipher_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_cipher = rsp_cipher_q;
  assign busy       = (state_q != IDLE);

endmodule
